// File: rtl/fetch_pc_seq.sv
// Fetch-stage PC sequencer with opcode/immediate pre-decode, zero-bubble
// taken-prediction redirect, epoch-tagged flush and a 2-entry decode buffer.
module fetch_pc_seq #(
    parameter int unsigned     XLEN    = 32,
    parameter logic [XLEN-1:0] PC_INIT = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            aresetn,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic [XLEN-1:0] i_imem_rdata,
    output logic            o_is_op_jal,
    output logic            o_is_op_branch,
    output logic [XLEN-1:0] o_immJ,
    output logic [XLEN-1:0] o_immB,
    output logic            o_instr_valid,
    output logic [XLEN-1:0] o_pc,
    input  logic [XLEN-1:0] i_branch_pc,
    input  logic            i_branch_taken,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_flush_pc,
    output logic            o_du_valid,
    input  logic            i_du_ready,
    output logic [XLEN-1:0] o_du_instr,
    output logic [XLEN-1:0] o_du_pc,
    output logic            o_du_pred_taken
);

    localparam logic [6:0]      OP_JAL    = 7'b1101111;
    localparam logic [6:0]      OP_BRANCH = 7'b1100011;
    localparam logic [XLEN-1:0] PC_STEP   = XLEN'(3'd4);

    logic [XLEN-1:0] r_pc;
    logic            r_ep;
    logic            r_infl;
    logic [XLEN-1:0] r_infl_pc;
    logic            r_infl_ep;
    logic [1:0]      r_cnt;
    logic            r_rd_ptr;
    logic            r_wr_ptr;
    logic [XLEN-1:0] r_fifo_pc    [2];
    logic [XLEN-1:0] r_fifo_instr [2];
    logic            r_fifo_pt    [2];

    logic            w_rsp_ok;
    logic            w_du_valid;
    logic            w_deq;
    logic            w_push;
    logic [XLEN-1:0] w_fa;
    logic [2:0]      w_credit;
    logic            w_req;
    logic [1:0]      w_cnt_nxt;

    // A response is only usable if its epoch matches and no flush is killing it
    assign w_rsp_ok   = r_infl & (r_infl_ep == r_ep) & ~i_flush;
    assign w_du_valid = (r_cnt != 2'd0) & ~i_flush;
    assign w_deq      = w_du_valid & i_du_ready;
    assign w_push     = w_rsp_ok;
    assign w_fa       = (w_rsp_ok & i_branch_taken) ? i_branch_pc : r_pc;

    // Occupancy after this cycle's pop plus the outstanding response must leave room
    assign w_credit   = {1'b0, r_cnt} + {2'b00, r_infl} - {2'b00, w_deq};
    assign w_req      = ~i_flush & (w_credit <= 3'd1);

    assign o_imem_req     = w_req;
    assign o_imem_addr    = w_fa;
    assign o_instr_valid  = w_rsp_ok;
    assign o_pc           = r_infl_pc;
    assign o_is_op_jal    = (i_imem_rdata[6:0] == OP_JAL);
    assign o_is_op_branch = (i_imem_rdata[6:0] == OP_BRANCH);
    assign o_immJ = {{(XLEN-20){i_imem_rdata[31]}}, i_imem_rdata[19:12],
                     i_imem_rdata[20], i_imem_rdata[30:21], 1'b0};
    assign o_immB = {{(XLEN-12){i_imem_rdata[31]}}, i_imem_rdata[7],
                     i_imem_rdata[30:25], i_imem_rdata[11:8], 1'b0};

    assign o_du_valid      = w_du_valid;
    assign o_du_instr      = r_fifo_instr[r_rd_ptr];
    assign o_du_pc         = r_fifo_pc[r_rd_ptr];
    assign o_du_pred_taken = w_du_valid & r_fifo_pt[r_rd_ptr];

    // Next buffer occupancy from simultaneous push/pop
    always_comb begin
        w_cnt_nxt = r_cnt;
        case ({w_push, w_deq})
            2'b10:   w_cnt_nxt = r_cnt + 2'd1;
            2'b01:   w_cnt_nxt = r_cnt - 2'd1;
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    // Fetch control state; a flush overrides prediction, enqueue and dequeue
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_pc      <= PC_INIT;
            r_ep      <= 1'b0;
            r_infl    <= 1'b0;
            r_infl_pc <= {XLEN{1'b0}};
            r_infl_ep <= 1'b0;
            r_cnt     <= 2'd0;
            r_rd_ptr  <= 1'b0;
            r_wr_ptr  <= 1'b0;
        end else if (i_flush) begin
            r_pc      <= i_flush_pc;
            r_ep      <= ~r_ep;
            r_infl    <= 1'b0;
            r_cnt     <= 2'd0;
            r_rd_ptr  <= 1'b0;
            r_wr_ptr  <= 1'b0;
        end else begin
            r_pc      <= w_req ? (w_fa + PC_STEP) : w_fa;
            r_infl    <= w_req;
            r_infl_pc <= w_fa;
            r_infl_ep <= r_ep;
            r_cnt     <= w_cnt_nxt;
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_deq)  r_rd_ptr <= ~r_rd_ptr;
        end
    end

    // Buffer storage, written at the tail for every accepted response
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < 2; i++) begin
                r_fifo_pc[i]    <= {XLEN{1'b0}};
                r_fifo_instr[i] <= {XLEN{1'b0}};
                r_fifo_pt[i]    <= 1'b0;
            end
        end else if (w_push) begin
            r_fifo_pc[r_wr_ptr]    <= r_infl_pc;
            r_fifo_instr[r_wr_ptr] <= i_imem_rdata;
            r_fifo_pt[r_wr_ptr]    <= i_branch_taken;
        end
    end

endmodule

// File: tb/tb_fetch_pc_seq.sv
// Scoreboard bench for fetch_pc_seq: directed phases push cycle-stamped
// expectations; negedge monitors pop and compare requests, responses and decode entries.
module tb_fetch_pc_seq;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] BEQ_M8 = 32'hFE00_0CE3;
    localparam logic [31:0] JAL_20 = 32'h0200_006F;

    logic        clk;
    logic        aresetn;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic [31:0] i_imem_rdata;
    logic        o_is_op_jal;
    logic        o_is_op_branch;
    logic [31:0] o_immJ;
    logic [31:0] o_immB;
    logic        o_instr_valid;
    logic [31:0] o_pc;
    logic [31:0] i_branch_pc;
    logic        i_branch_taken;
    logic        i_flush;
    logic [31:0] i_flush_pc;
    logic        o_du_valid;
    logic        i_du_ready;
    logic [31:0] o_du_instr;
    logic [31:0] o_du_pc;
    logic        o_du_pred_taken;

    fetch_pc_seq #(.XLEN(32), .PC_INIT(32'h0000_0100)) dut (
        .clk(clk), .aresetn(aresetn),
        .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_rdata(i_imem_rdata),
        .o_is_op_jal(o_is_op_jal), .o_is_op_branch(o_is_op_branch),
        .o_immJ(o_immJ), .o_immB(o_immB),
        .o_instr_valid(o_instr_valid), .o_pc(o_pc),
        .i_branch_pc(i_branch_pc), .i_branch_taken(i_branch_taken),
        .i_flush(i_flush), .i_flush_pc(i_flush_pc),
        .o_du_valid(o_du_valid), .i_du_ready(i_du_ready),
        .o_du_instr(o_du_instr), .o_du_pc(o_du_pc), .o_du_pred_taken(o_du_pred_taken)
    );

    typedef struct packed { logic [31:0] cyc; logic [31:0] addr; } req_t;
    typedef struct packed { logic [31:0] cyc; logic [31:0] pc; logic jal; logic br;
                            logic [31:0] immj; logic [31:0] immb; } rsp_t;
    typedef struct packed { logic [31:0] cyc; logic [31:0] pc; logic [31:0] instr; logic pt; } du_t;

    req_t q_req[$];
    rsp_t q_rsp[$];
    du_t  q_du[$];
    req_t m_req;
    rsp_t m_rsp;
    du_t  m_du;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          br_budget = 0;
    logic        last_req;
    logic [31:0] last_addr;
    logic [31:0] mem [logic [31:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return NOP;
    endfunction

    task automatic er(input int c, input logic [31:0] a);
        q_req.push_back('{cyc: 32'(c), addr: a});
    endtask

    task automatic ers(input int c, input logic [31:0] pc, input logic jal, input logic br,
                       input logic [31:0] immj, input logic [31:0] immb);
        q_rsp.push_back('{cyc: 32'(c), pc: pc, jal: jal, br: br, immj: immj, immb: immb});
    endtask

    task automatic ern(input int c, input logic [31:0] pc);
        ers(c, pc, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic ed(input int c, input logic [31:0] pc, input logic [31:0] instr, input logic pt);
        q_du.push_back('{cyc: 32'(c), pc: pc, instr: instr, pt: pt});
    endtask

    // Negedge monitors: pop expectations whenever the DUT presents an output
    always @(negedge clk) begin
        if (aresetn) begin
            if (o_imem_req && q_req.size() > 0) begin
                m_req = q_req.pop_front();
                chk("req_cycle", 32'(cyc), m_req.cyc);
                chk("req_addr", o_imem_addr, m_req.addr);
            end
            if (o_instr_valid && q_rsp.size() > 0) begin
                m_rsp = q_rsp.pop_front();
                chk("rsp_cycle", 32'(cyc), m_rsp.cyc);
                chk("rsp_pc", o_pc, m_rsp.pc);
                chk("rsp_is_jal", 32'(o_is_op_jal), 32'(m_rsp.jal));
                chk("rsp_is_branch", 32'(o_is_op_branch), 32'(m_rsp.br));
                chk("rsp_immJ", o_immJ, m_rsp.immj);
                chk("rsp_immB", o_immB, m_rsp.immb);
            end
            if (o_du_valid && i_du_ready && q_du.size() > 0) begin
                m_du = q_du.pop_front();
                chk("du_cycle", 32'(cyc), m_du.cyc);
                chk("du_pc", o_du_pc, m_du.pc);
                chk("du_instr", o_du_instr, m_du.instr);
                chk("du_pred_taken", 32'(o_du_pred_taken), 32'(m_du.pt));
            end
        end
    end

    // Drive one cycle: memory data, control inputs, then a static predictor on pre-decode
    task automatic drive(input logic flush, input logic [31:0] fpc, input logic rdy,
                         input logic ft, input logic [31:0] ftgt);
        i_imem_rdata   = last_req ? mem_word(last_addr) : 32'h0;
        i_flush        = flush;
        i_flush_pc     = fpc;
        i_du_ready     = rdy;
        i_branch_taken = 1'b0;
        i_branch_pc    = 32'h0;
        #1;
        if (ft) begin
            i_branch_taken = 1'b1;
            i_branch_pc    = ftgt;
        end else if (o_instr_valid && o_is_op_jal) begin
            i_branch_taken = 1'b1;
            i_branch_pc    = o_pc + o_immJ;
        end else if (o_instr_valid && o_is_op_branch && o_immB[31] && br_budget > 0) begin
            i_branch_taken = 1'b1;
            i_branch_pc    = o_pc + o_immB;
            br_budget--;
        end
        #1;
        last_req  = o_imem_req;
        last_addr = o_imem_addr;
    endtask

    task automatic step(input logic flush, input logic [31:0] fpc, input logic rdy,
                        input logic ft, input logic [31:0] ftgt);
        @(posedge clk);
        #1;
        cyc++;
        drive(flush, fpc, rdy, ft, ftgt);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic do_reset(input logic flush, input logic [31:0] fpc);
        aresetn        = 1'b0;
        i_flush        = 1'b0;
        i_du_ready     = 1'b0;
        i_branch_taken = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        aresetn  = 1'b1;
        cyc      = 0;
        last_req = 1'b0;
        drive(flush, fpc, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic end_phase();
        chk("req_left", 32'(q_req.size()), 32'd0);
        chk("rsp_left", 32'(q_rsp.size()), 32'd0);
        chk("du_left", 32'(q_du.size()), 32'd0);
        q_req.delete();
        q_rsp.delete();
        q_du.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        aresetn = 1'b0; i_imem_rdata = 32'h0; i_branch_pc = 32'h0; i_branch_taken = 1'b0;
        i_flush = 1'b0; i_flush_pc = 32'h0; i_du_ready = 1'b0;
        last_req = 1'b0; last_addr = 32'h0;

        // Sequential fetch plus backward BEQ at 0x108 predicted taken once
        mem.delete(); mem[32'h108] = BEQ_M8; br_budget = 1;
        er(0, 32'h100); er(1, 32'h104); er(2, 32'h108); er(3, 32'h100);
        er(4, 32'h104); er(5, 32'h108); er(6, 32'h10C); er(7, 32'h110);
        ern(1, 32'h100); ern(2, 32'h104);
        ers(3, 32'h108, 1'b0, 1'b1, 32'hFFF0_07E0, 32'hFFFF_FFF8);
        ern(4, 32'h100); ern(5, 32'h104);
        ers(6, 32'h108, 1'b0, 1'b1, 32'hFFF0_07E0, 32'hFFFF_FFF8);
        ern(7, 32'h10C);
        ed(2, 32'h100, NOP, 1'b0); ed(3, 32'h104, NOP, 1'b0); ed(4, 32'h108, BEQ_M8, 1'b1);
        ed(5, 32'h100, NOP, 1'b0); ed(6, 32'h104, NOP, 1'b0); ed(7, 32'h108, BEQ_M8, 1'b0);
        ed(8, 32'h10C, NOP, 1'b0);
        do_reset(1'b0, 32'h0);
        run(9);
        end_phase();
        chk("pre_reset_du_valid", 32'(o_du_valid), 32'd1);
        aresetn = 1'b0;
        #1;
        chk("rst_imem_req", 32'(o_imem_req), 32'd1);
        chk("rst_imem_addr", o_imem_addr, 32'h100);
        chk("rst_instr_valid", 32'(o_instr_valid), 32'd0);
        chk("rst_du_valid", 32'(o_du_valid), 32'd0);
        chk("rst_du_pred_taken", 32'(o_du_pred_taken), 32'd0);

        // JAL at 0x104 with +0x20 redirects the very next request to 0x124
        mem.delete(); mem[32'h104] = JAL_20; br_budget = 0;
        er(0, 32'h100); er(1, 32'h104); er(2, 32'h124); er(3, 32'h128); er(4, 32'h12C);
        ern(1, 32'h100); ers(2, 32'h104, 1'b1, 1'b0, 32'h20, 32'h20);
        ern(3, 32'h124); ern(4, 32'h128);
        ed(2, 32'h100, NOP, 1'b0); ed(3, 32'h104, JAL_20, 1'b1);
        ed(4, 32'h124, NOP, 1'b0); ed(5, 32'h128, NOP, 1'b0);
        do_reset(1'b0, 32'h0);
        run(6);
        end_phase();

        // Flush at cycle 3 together with a taken prediction and a ready decoder
        mem.delete(); mem[32'h108] = BEQ_M8; br_budget = 0;
        er(0, 32'h100); er(1, 32'h104); er(2, 32'h108);
        er(4, 32'h400); er(5, 32'h404); er(6, 32'h408); er(7, 32'h40C);
        ern(1, 32'h100); ern(2, 32'h104); ern(5, 32'h400); ern(6, 32'h404); ern(7, 32'h408);
        ed(2, 32'h100, NOP, 1'b0); ed(6, 32'h400, NOP, 1'b0);
        ed(7, 32'h404, NOP, 1'b0); ed(8, 32'h408, NOP, 1'b0);
        do_reset(1'b0, 32'h0);
        run(2);
        step(1'b1, 32'h400, 1'b1, 1'b1, 32'h100);
        chk("flush_imem_req", 32'(o_imem_req), 32'd0);
        chk("flush_du_valid", 32'(o_du_valid), 32'd0);
        chk("flush_instr_valid", 32'(o_instr_valid), 32'd0);
        run(6);
        end_phase();

        // Decode stall for 5 cycles: buffer fills, issue stops, head holds
        mem.delete(); br_budget = 0;
        er(0, 32'h100); er(1, 32'h104); er(2, 32'h108);
        er(8, 32'h10C); er(9, 32'h110); er(10, 32'h114);
        ern(1, 32'h100); ern(2, 32'h104); ern(3, 32'h108); ern(9, 32'h10C); ern(10, 32'h110);
        ed(2, 32'h100, NOP, 1'b0); ed(8, 32'h104, NOP, 1'b0); ed(9, 32'h108, NOP, 1'b0);
        ed(10, 32'h10C, NOP, 1'b0); ed(11, 32'h110, NOP, 1'b0);
        do_reset(1'b0, 32'h0);
        run(2);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            chk("stall_imem_req", 32'(o_imem_req), 32'd0);
            chk("stall_du_pc", o_du_pc, 32'h104);
            chk("stall_du_valid", 32'(o_du_valid), 32'd1);
        end
        run(5);
        end_phase();

        // Address wrap: flush to 0xFFFF_FFF8 in the first cycle after reset
        mem.delete(); br_budget = 0;
        er(1, 32'hFFFF_FFF8); er(2, 32'hFFFF_FFFC); er(3, 32'h0000_0000); er(4, 32'h0000_0004);
        ern(2, 32'hFFFF_FFF8); ern(3, 32'hFFFF_FFFC); ern(4, 32'h0000_0000);
        ed(3, 32'hFFFF_FFF8, NOP, 1'b0); ed(4, 32'hFFFF_FFFC, NOP, 1'b0);
        ed(5, 32'h0000_0000, NOP, 1'b0); ed(6, 32'h0000_0004, NOP, 1'b0);
        do_reset(1'b1, 32'hFFFF_FFF8);
        run(7);
        end_phase();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
